counter_run_ctrl: RTL and testbench



---
 rtl/counter_run_ctrl_pkg.sv | 23 ++
 rtl/counter_run_ctrl_tick.sv | 28 ++
 rtl/counter_run_ctrl.sv | 124 ++++++++++++
 tb/tb_counter_run_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_run_ctrl_pkg.sv
// Shared definitions for the board counter run controller: FSM encodings and
// the board-level default pacing and terminal-count constants.
package counter_run_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_LAP   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int          DEF_N     = 16;
  localparam int          DEF_DIV   = 500000;
  localparam int          DEF_DIV_W = 20;
  localparam logic [15:0] DEF_LIMIT = 16'hFFFF;

  // RUN and LAP both advance the counter; LAP only freezes the display.
  function automatic logic is_counting(state_t s);
    return (s == S_RUN) || (s == S_LAP);
  endfunction

endpackage

// File: rtl/counter_run_ctrl_tick.sv
// Count-step prescaler: advances while run, keeps its partial period while
// hold, and returns to zero on clr or when neither run nor hold is asserted.
module tick_gen #(
  parameter int DIV   = 4,
  parameter int DIV_W = 3
) (
  input  logic clk,
  input  logic aclr,
  input  logic run,
  input  logic hold,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr)      cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (run)   cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    else if (!hold) cnt <= '0;
  end

endmodule

// File: rtl/counter_run_ctrl.sv
// Run controller for the board counter: turns the start/stop and lap/clear
// pushbuttons into paced enable pulses, a clear pulse and the display select.
module counter_run_ctrl
  import counter_run_ctrl_pkg::*;
#(
  parameter int          N     = DEF_N,
  parameter int          DIV   = DEF_DIV,
  parameter int          DIV_W = DEF_DIV_W,
  parameter logic [N-1:0] LIMIT = N'(DEF_LIMIT)
) (
  input  logic         clk,
  input  logic         aclr,
  input  logic         start_n,
  input  logic         lap_n,
  input  logic [N-1:0] count_q,
  output logic         cnt_en,
  output logic         cnt_clr_n,
  output logic [N-1:0] disp,
  output logic         running,
  output logic         done
);

  state_t       state, nxt;
  logic [2:0]   start_sync, lap_sync;
  logic         start_ev, lap_raw, lap_ev;
  logic         tick, at_limit, clr_nxt, latch_lap;
  logic         pre_run, pre_hold, pre_clr;
  logic [N-1:0] lap_reg;

  // Synchronizers idle high so a button held through reset needs a fresh
  // falling edge; [2] is the previous synchronized sample for edge detect.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) start_sync <= 3'b111;
    else       start_sync <= {start_sync[1:0], start_n};
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) lap_sync <= 3'b111;
    else       lap_sync <= {lap_sync[1:0], lap_n};
  end

  assign start_ev = start_sync[2] & ~start_sync[1];
  assign lap_raw  = lap_sync[2] & ~lap_sync[1];
  assign lap_ev   = lap_raw & ~start_ev;

  assign pre_run  = is_counting(state);
  assign pre_hold = (state == S_PAUSE);
  assign pre_clr  = (state == S_IDLE) || (state == S_DONE);

  tick_gen #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_tick (
    .clk  (clk),
    .aclr (aclr),
    .run  (pre_run),
    .hold (pre_hold),
    .clr  (pre_clr),
    .tick (tick)
  );

  assign at_limit = (count_q == LIMIT);

  // Reaching the terminal count outranks any button in the same cycle.
  always_comb begin
    nxt       = state;
    clr_nxt   = 1'b1;
    latch_lap = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_ev)    nxt = S_RUN;
        else if (lap_ev) clr_nxt = 1'b0;
      end
      S_RUN: begin
        if (tick && at_limit) nxt = S_DONE;
        else if (start_ev)    nxt = S_PAUSE;
        else if (lap_ev) begin
          nxt       = S_LAP;
          latch_lap = 1'b1;
        end
      end
      S_LAP: begin
        if (tick && at_limit) nxt = S_DONE;
        else if (start_ev)    nxt = S_PAUSE;
        else if (lap_ev)      nxt = S_RUN;
      end
      S_PAUSE: begin
        if (start_ev) nxt = S_RUN;
        else if (lap_ev) begin
          nxt     = S_IDLE;
          clr_nxt = 1'b0;
        end
      end
      S_DONE: begin
        if (lap_ev) begin
          nxt     = S_IDLE;
          clr_nxt = 1'b0;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state     <= S_IDLE;
      cnt_en    <= 1'b0;
      cnt_clr_n <= 1'b1;
      disp      <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
      lap_reg   <= '0;
    end else begin
      state     <= nxt;
      running   <= is_counting(nxt);
      done      <= (nxt == S_DONE);
      cnt_clr_n <= clr_nxt;
      cnt_en    <= tick && !at_limit;
      if (latch_lap) lap_reg <= count_q;
      disp      <= (state == S_LAP) ? lap_reg : count_q;
    end
  end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Randomized bench for counter_run_ctrl with a cycle-level behavioural model
// and a behavioural board counter closing the count_q feedback loop.
module tb_counter_run_ctrl;

  localparam int DIV   = 4;
  localparam int LIMIT = 5;

  logic        clk = 1'b0;
  logic        aclr;
  logic        start_n, lap_n;
  logic [15:0] count_q;
  logic        cnt_en, cnt_clr_n, running, done;
  logic [15:0] disp;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  counter_run_ctrl #(
    .N     (16),
    .DIV   (DIV),
    .DIV_W (3),
    .LIMIT (16'(LIMIT))
  ) dut (
    .clk       (clk),
    .aclr      (aclr),
    .start_n   (start_n),
    .lap_n     (lap_n),
    .count_q   (count_q),
    .cnt_en    (cnt_en),
    .cnt_clr_n (cnt_clr_n),
    .disp      (disp),
    .running   (running),
    .done      (done)
  );

  // Board counter driven by the DUT.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr)          count_q <= '0;
    else if (!cnt_clr_n) count_q <= '0;
    else if (cnt_en)     count_q <= count_q + 16'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_RUN, M_LAP, M_PAUSE, M_DONE} mode_t;
  mode_t m_mode;
  bit    sh[3], lh[3];   // button samples from 1, 2, 3 edges ago
  int    m_p, m_count, m_disp, m_lap;
  bit    m_en, m_clr_n;

  function automatic void model_reset();
    m_mode = M_IDLE;
    for (int i = 0; i < 3; i++) begin sh[i] = 1; lh[i] = 1; end
    m_p = 0; m_count = 0; m_disp = 0; m_lap = 0; m_en = 0; m_clr_n = 1;
  endfunction

  function automatic void model_step(input bit s_in, input bit l_in);
    bit    s_ev, l_ev, counting, tick;
    mode_t nm;
    int    nc;
    // a press is seen on the third edge that samples it low
    s_ev = (sh[1] == 0) && (sh[2] == 1);
    l_ev = (lh[1] == 0) && (lh[2] == 1) && !s_ev;
    sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = s_in;
    lh[2] = lh[1]; lh[1] = lh[0]; lh[0] = l_in;
    counting = (m_mode == M_RUN) || (m_mode == M_LAP);
    tick = counting && (m_p == DIV - 1);
    nc = !m_clr_n ? 0 : (m_en ? m_count + 1 : m_count);
    m_disp = (m_mode == M_LAP) ? m_lap : m_count;
    m_en = tick && (m_count != LIMIT);
    m_clr_n = 1;
    nm = m_mode;
    if (tick && m_count == LIMIT) nm = M_DONE;
    else case (m_mode)
      M_IDLE:  if (s_ev) nm = M_RUN; else if (l_ev) m_clr_n = 0;
      M_RUN:   if (s_ev) nm = M_PAUSE; else if (l_ev) begin nm = M_LAP; m_lap = m_count; end
      M_LAP:   if (s_ev) nm = M_PAUSE; else if (l_ev) nm = M_RUN;
      M_PAUSE: if (s_ev) nm = M_RUN; else if (l_ev) begin nm = M_IDLE; m_clr_n = 0; end
      M_DONE:  if (l_ev) begin nm = M_IDLE; m_clr_n = 0; end
      default: nm = M_IDLE;
    endcase
    if (counting)              m_p = (m_p + 1) % DIV;
    else if (m_mode != M_PAUSE) m_p = 0;
    m_mode = nm;
    m_count = nc;
  endfunction

  always @(posedge clk) begin
    if (!aclr) model_reset();
    else       model_step(start_n, lap_n);
    #1;
    chk("cnt_en",    32'(cnt_en),    32'(m_en));
    chk("cnt_clr_n", 32'(cnt_clr_n), 32'(m_clr_n));
    chk("disp",      32'(disp),      32'(m_disp));
    chk("running",   32'(running),   32'((m_mode == M_RUN) || (m_mode == M_LAP)));
    chk("done",      32'(done),      32'(m_mode == M_DONE));
    chk("count_q",   32'(count_q),   32'(m_count));
  end

  // ---------------- stimulus ----------------
  task automatic press(input bit s, input bit l, input int hold);
    @(negedge clk);
    if (s) start_n = 0;
    if (l) lap_n = 0;
    repeat (hold) @(negedge clk);
    start_n = 1;
    lap_n = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_count(input int v, input int budget);
    for (int i = 0; i < budget && count_q != 16'(v); i++) @(negedge clk);
    chk($sformatf("reach_count_%0d", v), 32'(count_q), 32'(v));
  endtask

  initial begin
    int s_hold, l_hold;
    aclr = 0; start_n = 0; lap_n = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_cnt_en", 32'(cnt_en), 0);
    chk("rst_clr_n",  32'(cnt_clr_n), 1);
    chk("rst_disp",   32'(disp), 0);
    chk("rst_run",    32'(running), 0);
    start_n = 1; lap_n = 1;
    @(negedge clk);
    aclr = 1;
    repeat (6) @(negedge clk);
    chk("idle_after_rst", 32'(running), 0);

    // start, count, lap freeze, unfreeze
    press(1, 0, 2);
    chk("run_after_start", 32'(running), 1);
    wait_count(2, 40);
    press(0, 1, 1);
    wait_count(4, 40);
    chk("disp_frozen", 32'(disp), 32'(m_lap));
    press(0, 1, 1);
    repeat (2) @(negedge clk);
    chk("disp_live", 32'(disp), 32'(count_q));

    // pause, resume with partial period, clear from pause
    press(1, 0, 1);
    chk("paused", 32'(running), 0);
    repeat (6) @(negedge clk);
    press(1, 0, 1);
    repeat (3) @(negedge clk);
    press(1, 0, 1);
    press(0, 1, 1);
    chk("idle_clr_count", 32'(count_q), 0);

    // run to terminal count
    press(1, 0, 1);
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    chk("done_reached", 32'(done), 1);
    repeat (10) @(negedge clk);
    chk("done_hold_count", 32'(count_q), 32'(LIMIT));
    press(1, 0, 1);
    chk("done_ignores_start", 32'(done), 1);
    press(0, 1, 1);
    chk("done_lap_idle", 32'(done), 0);
    chk("done_lap_clr", 32'(count_q), 0);

    // simultaneous buttons in RUN, then async reset mid-run
    press(1, 0, 1);
    repeat (5) @(negedge clk);
    press(1, 1, 1);
    chk("both_pause", 32'(running), 0);
    press(1, 0, 1);
    repeat (2) @(negedge clk);
    #2 aclr = 0;
    #1;
    chk("arst_cnt_en", 32'(cnt_en), 0);
    chk("arst_running", 32'(running), 0);
    @(negedge clk);
    aclr = 1;
    repeat (12) @(negedge clk);
    chk("arst_stays_idle", 32'(count_q), 0);

    // random button activity with occasional resets
    s_hold = 0; l_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      aclr = ($urandom_range(0, 399) != 0);
      if (s_hold > 0) s_hold--;
      else if ($urandom_range(0, 39) == 0) s_hold = $urandom_range(1, 5);
      if (l_hold > 0) l_hold--;
      else if ($urandom_range(0, 39) == 0) l_hold = $urandom_range(1, 5);
      start_n = (s_hold == 0);
      lap_n   = (l_hold == 0);
    end
    @(negedge clk);
    aclr = 1; start_n = 1; lap_n = 1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
